ram_copy_engine: RTL
====================

# ram_copy_engine

Initiator-side controller for the single-port synchronous RAM (one read-or-write per cycle, registered read data one cycle after address). It accepts a start command and then fills a block with a constant or copies a block within the same RAM. It sits between the ALU/control sequencer and the RAM port, and owns that port for the duration of a command.

## Interface
- DATA_WIDTH, 8, RAM word width in bits
- ADDR_WIDTH, 10, RAM address width; RAM depth is 2**ADDR_WIDTH
- clk  in  1  single clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- mode  in  1  0 = COPY, 1 = FILL
- src_addr  in  ADDR_WIDTH  COPY source base address
- dst_addr  in  ADDR_WIDTH  destination base address (both modes)
- len  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH
- fill_data  in  DATA_WIDTH  FILL pattern
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- we_a  out  1  RAM write enable
- addr_a  out  ADDR_WIDTH  RAM address
- din_a  out  DATA_WIDTH  RAM write data
- dout_a  in  DATA_WIDTH  RAM read data, valid the cycle after a read address

## Operation
- Reset values: busy=0, done=0, we_a=0, addr_a=0, din_a=0; state IDLE. Reset is asynchronous, so reset mid-command aborts immediately with we_a low; no partial write completes after reset_n falls.
- The block captures start, mode, src_addr, dst_addr, len and fill_data at the start edge. Later input changes have no effect until the next IDLE.
- States: IDLE, FILL_WR, COPY_RD, COPY_WR, DONE.
  - IDLE: start=1 and len=0 -> DONE.
  - IDLE: start=1 and mode=FILL -> FILL_WR.
  - IDLE: start=1 and mode=COPY -> COPY_RD.
  - FILL_WR: we_a=1, addr_a=dst+off, din_a=fill_data. Advances offset. Goes to DONE after word len-1.
  - COPY_RD: we_a=0, addr_a=src+off. Next state is COPY_WR.
  - COPY_WR: we_a=1, addr_a=dst+off, din_a=dout_a (direct pass-through). Goes to COPY_RD, or to DONE after the last word.
  - DONE: done=1 for one cycle, then IDLE.
- Direction rule:
  - COPY with dst_addr > src_addr (unsigned) runs descending, offset len-1 down to 0.
  - Otherwise COPY runs ascending, offset 0 up to len-1.
  - This gives memmove semantics for ranges that do not wrap.
  - FILL always runs ascending.
- Address arithmetic is base+offset modulo 2**ADDR_WIDTH; wrap past the top address is legal.
- len=2**ADDR_WIDTH touches every location exactly once. The offset counter is ADDR_WIDTH+1 bits wide.
- While the block is not busy, addr_a, din_a and we_a hold their reset values (0).
- start asserted while busy or in DONE is ignored, not queued.
- src_addr == dst_addr COPY runs normally, rewriting the same data.

## Timing
- Start sampled at edge k: busy=1 from cycle k+1 through the last access cycle. In DONE, busy=0 and done=1.
- FILL of N words: writes in cycles k+1..k+N, done in cycle k+N+1. Throughput is 1 word/cycle.
- COPY of N words: 2 cycles/word, done in cycle k+2N+1.
- len=0: done in cycle k+1, busy never asserts, no RAM access.
- Earliest next accepted start is the cycle after done.
- Only combinational input-to-output path: dout_a -> din_a in COPY_WR.

## Structure
- Package ram_ctrl_pkg holds:
  - state_t enum (IDLE, FILL_WR, COPY_RD, COPY_WR, DONE)
  - mode_t enum (MODE_COPY=0, MODE_FILL=1)
- One sub-module is natural: ram_addr_gen.
  - Holds base register and up/down offset counter.
  - Outputs base+offset and a last-word flag.
  - One instance for source, one for destination.

## Test plan
- FILL dst=0x010, len=4, fill_data=0xA5 -> writes to 0x010..0x013 in cycles k+1..k+4; done at k+5; readback all 0xA5; 0x00F and 0x014 untouched.
- COPY src=0x000 holding 1,2,3,4, dst=0x100, len=4 -> 0x100..0x103 = 1,2,3,4; done at k+9.
- Overlapping COPY src=0x020 holding 1..8, dst=0x022, len=8 -> descending; 0x022..0x029 = 1..8.
- FILL dst=0x3FE, len=4, fill_data=0x5A -> writes 0x3FE, 0x3FF, 0x000, 0x001.
- len=0 -> done at k+1, we_a never asserted. Second start while busy -> ignored, only one done pulse.
- reset_n low at cycle k+3 of a COPY of len=8 -> we_a, busy, done drop immediately; after release, IDLE and a new FILL completes correctly.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_ctrl_pkg
//  Purpose  : Shared types for the RAM copy/fill engine (FSM states, modes)
//  Revision : 1.0 - initial release
// ============================================================================
package ram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL_WR = 3'd1,
        COPY_RD = 3'd2,
        COPY_WR = 3'd3,
        DONE    = 3'd4
    } state_t;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } mode_t;

endpackage
`default_nettype wire

// File: rtl/ram_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ram_addr_gen
//  Purpose  : Base register plus up/down word-offset counter. Produces
//             base+offset (modulo RAM depth) and a flag marking the final word.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_addr_gen #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  step,
    input  logic                  down_in,
    input  logic [ADDR_WIDTH-1:0] base_in,
    input  logic [ADDR_WIDTH:0]   len_in,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH:0] C_ONE = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   off_q,  off_d;
    logic [ADDR_WIDTH:0]   end_q,  end_d;
    logic                  down_q, down_d;
    logic [ADDR_WIDTH:0]   w_len_m1;

    // Offset is one bit wider than the address so a full-depth count fits;
    // the final offset is len-1 going up, 0 going down.
    assign w_len_m1 = len_in - C_ONE;
    assign addr     = base_q + off_q[ADDR_WIDTH-1:0];
    assign last     = (off_q == end_q);

    // Counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q <= '0;
            off_q  <= '0;
            end_q  <= '0;
            down_q <= 1'b0;
        end else begin
            base_q <= base_d;
            off_q  <= off_d;
            end_q  <= end_d;
            down_q <= down_d;
        end
    end

    // Load a new walk on command accept, otherwise step one word per request
    always_comb begin
        base_d = base_q;
        off_d  = off_q;
        end_d  = end_q;
        down_d = down_q;
        if (load) begin
            base_d = base_in;
            down_d = down_in;
            off_d  = down_in ? w_len_m1 : '0;
            end_d  = down_in ? '0 : w_len_m1;
        end else if (step) begin
            off_d  = down_q ? (off_q - C_ONE) : (off_q + C_ONE);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ram_copy_engine
//  Purpose  : Single-port RAM initiator that fills a block with a constant or
//             copies a block (memmove direction) within the same RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_copy_engine
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [DATA_WIDTH-1:0] fill_data,
    output logic                  busy,
    output logic                  done,
    output logic                  we_a,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] din_a,
    input  logic [DATA_WIDTH-1:0] dout_a
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] fill_q,  fill_d;

    logic                  w_load;
    logic                  w_down;
    logic                  w_src_step;
    logic                  w_dst_step;
    logic [ADDR_WIDTH-1:0] w_src_addr;
    logic [ADDR_WIDTH-1:0] w_dst_addr;
    logic                  w_src_last;
    logic                  w_dst_last;

    // A copy whose destination lies above the source walks downward so the
    // overlapping tail is read before it is overwritten.
    assign w_load     = (state_q == IDLE) && start;
    assign w_down     = (mode_t'(mode) == MODE_COPY) && (dst_addr > src_addr);
    assign w_src_step = (state_q == COPY_WR);
    assign w_dst_step = (state_q == FILL_WR) || (state_q == COPY_WR);

    ram_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_src_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_load),
        .step    (w_src_step),
        .down_in (w_down),
        .base_in (src_addr),
        .len_in  (len),
        .addr    (w_src_addr),
        .last    (w_src_last)
    );

    ram_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dst_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_load),
        .step    (w_dst_step),
        .down_in (w_down),
        .base_in (dst_addr),
        .len_in  (len),
        .addr    (w_dst_addr),
        .last    (w_dst_last)
    );

    // State and captured fill pattern
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    fill_d = fill_data;
                    if (len == '0)
                        state_d = DONE;
                    else if (mode_t'(mode) == MODE_FILL)
                        state_d = FILL_WR;
                    else
                        state_d = COPY_RD;
                end
            end
            FILL_WR: if (w_dst_last) state_d = DONE;
            COPY_RD: state_d = COPY_WR;
            COPY_WR: state_d = w_src_last ? DONE : COPY_RD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM port and status decode; port idles at zero outside active states
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        we_a   = 1'b0;
        addr_a = '0;
        din_a  = '0;
        case (state_q)
            FILL_WR: begin
                busy   = 1'b1;
                we_a   = 1'b1;
                addr_a = w_dst_addr;
                din_a  = fill_q;
            end
            COPY_RD: begin
                busy   = 1'b1;
                addr_a = w_src_addr;
            end
            COPY_WR: begin
                busy   = 1'b1;
                we_a   = 1'b1;
                addr_a = w_dst_addr;
                din_a  = dout_a;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire
